// File: rtl/pattern_sequencer_pkg.sv
// Shared types for the pattern sequencer: generator modes, sequencer states and
// a helper that finds the next enabled mode in a mask.
package pattern_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      IDLE    = 3'd0,
      REGULAR = 3'd1,
      CONST   = 3'd2,
      WHITE1  = 3'd3,
      BLACK1  = 3'd4,
      WHITE2  = 3'd5,
      BLACK2  = 3'd6,
      RAMP    = 3'd7
   } mode_t;

   // Prefixed because IDLE is already taken by mode_t in this scope.
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_GAP  = 2'd2
   } seq_state_t;

   // Lowest enabled mode strictly above cur; IDLE when none remains.
   function automatic mode_t next_mode(input logic [6:0] mask, input mode_t cur);
      mode_t res;
      res = IDLE;
      for (int i = 7; i >= 1; i--) begin
         if (i > int'(cur) && mask[i-1])
            res = mode_t'(MODE_W'(i));
      end
      return res;
   endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Host configuration plus pattern-generator control bundle.
// master: the sequencer; slave: the host/generator side.
interface pattern_sequencer_if #(
   parameter int LINE_W   = 13,
   parameter int LINES_W  = 8,
   parameter int FRAMES_W = 4,
   parameter int GAP_W    = 8
);
   logic                start;
   logic                abort;
   logic [6:0]          mode_mask;
   logic [LINE_W-1:0]   line_len;
   logic [LINES_W-1:0]  lines;
   logic [FRAMES_W-1:0] frames;
   logic [GAP_W-1:0]    gap_len;
   logic [11:0]         const_in;
   logic [1:0]          x_in;
   logic [1:0]          y_in;
   logic                loop;

   logic                f_sync;
   logic                sync;
   logic [2:0]          Mode;
   logic [11:0]         constVal;
   logic [1:0]          X;
   logic [1:0]          Y;
   logic                busy;
   logic                done;

   modport master (
      input  start, abort, mode_mask, line_len, lines, frames, gap_len,
             const_in, x_in, y_in, loop,
      output f_sync, sync, Mode, constVal, X, Y, busy, done
   );

   modport slave (
      output start, abort, mode_mask, line_len, lines, frames, gap_len,
             const_in, x_in, y_in, loop,
      input  f_sync, sync, Mode, constVal, X, Y, busy, done
   );
endinterface

// File: rtl/pattern_line_timer.sv
// Cycle / line / frame counters for one mode. Strobes look one cycle ahead so
// the sequencer can register its outputs for the cycle they describe.
module pattern_line_timer #(
   parameter int LINE_W   = 13,
   parameter int LINES_W  = 8,
   parameter int FRAMES_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                run,
   input  logic [LINE_W-1:0]   line_len,
   input  logic [LINES_W-1:0]  lines,
   input  logic [FRAMES_W-1:0] frames,
   output logic                line_start,
   output logic                frame_start,
   output logic                mode_end
);

   logic [LINE_W-1:0]   cyc;
   logic [LINES_W-1:0]  ln;
   logic [FRAMES_W-1:0] fr;
   logic                cyc_last;
   logic                ln_last;
   logic                fr_last;

   // Limits arrive already clamped (line_len >= 2, lines/frames >= 1).
   assign cyc_last = (cyc == line_len - LINE_W'(1));
   assign ln_last  = (ln == lines - LINES_W'(1));
   assign fr_last  = (fr == frames - FRAMES_W'(1));

   assign line_start  = run && cyc_last;
   assign frame_start = line_start && ln_last;
   assign mode_end    = frame_start && fr_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= '0;
         ln  <= '0;
         fr  <= '0;
      end else if (clr) begin
         cyc <= '0;
         ln  <= '0;
         fr  <= '0;
      end else if (run) begin
         if (cyc_last) begin
            cyc <= '0;
            if (ln_last) begin
               ln <= '0;
               fr <= fr_last ? '0 : fr + FRAMES_W'(1);
            end else begin
               ln <= ln + LINES_W'(1);
            end
         end else begin
            cyc <= cyc + LINE_W'(1);
         end
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Steps the pattern generator through the enabled modes, emitting line/frame syncs.
// Optional feature macro: PATTERN_SEQ_LOOP_EN (honour the loop input).
module pattern_sequencer
   import pattern_pkg::*;
#(
   parameter int LINE_W   = 13,
   parameter int LINES_W  = 8,
   parameter int FRAMES_W = 4,
   parameter int GAP_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   pattern_sequencer_if.master bus
);

   seq_state_t          st, st_nxt;
   mode_t               mode_q, mode_nxt;
   mode_t               pend_q, pend_nxt;
   mode_t               nm;
   logic [GAP_W-1:0]    gap_cnt, gap_cnt_nxt;

   logic [6:0]          mask_q;
   logic [LINE_W-1:0]   len_q;
   logic [LINES_W-1:0]  lines_q;
   logic [FRAMES_W-1:0] frames_q;
   logic [GAP_W-1:0]    gap_q;
   logic [11:0]         const_q;
   logic [1:0]          x_q;
   logic [1:0]          y_q;

   logic                latch;
   logic                tmr_clr;
   logic                tmr_run;
   logic                line_start;
   logic                frame_start;
   logic                mode_end;

   logic [11:0]         const_src;
   logic [1:0]          x_src;
   logic [1:0]          y_src;

   logic                sync_n, fsync_n, done_n, busy_n;
   logic [11:0]         const_n;
   logic [1:0]          x_n, y_n;
   logic                sync_q, fsync_q, done_q, busy_q;
   logic [11:0]         const_out_q;
   logic [1:0]          x_out_q, y_out_q;

`ifdef PATTERN_SEQ_LOOP_EN
   logic                loop_q;
`else
   logic                loop_unused;
   assign loop_unused = bus.loop;
`endif

   assign tmr_run = (st == SEQ_RUN);

   pattern_line_timer #(
      .LINE_W  (LINE_W),
      .LINES_W (LINES_W),
      .FRAMES_W(FRAMES_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (tmr_clr),
      .run        (tmr_run),
      .line_len   (len_q),
      .lines      (lines_q),
      .frames     (frames_q),
      .line_start (line_start),
      .frame_start(frame_start),
      .mode_end   (mode_end)
   );

   // Configuration is data: captured on start, no reset needed.
   always_ff @(posedge clk) begin
      if (latch) begin
         mask_q   <= bus.mode_mask;
         len_q    <= (bus.line_len < LINE_W'(2)) ? LINE_W'(2) : bus.line_len;
         lines_q  <= (bus.lines == '0) ? LINES_W'(1) : bus.lines;
         frames_q <= (bus.frames == '0) ? FRAMES_W'(1) : bus.frames;
         gap_q    <= bus.gap_len;
         const_q  <= bus.const_in;
         x_q      <= bus.x_in;
         y_q      <= bus.y_in;
`ifdef PATTERN_SEQ_LOOP_EN
         loop_q   <= bus.loop;
`endif
      end
   end

   // The first cycle after start must already show the new constants.
   assign const_src = latch ? bus.const_in : const_q;
   assign x_src     = latch ? bus.x_in : x_q;
   assign y_src     = latch ? bus.y_in : y_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= SEQ_IDLE;
         mode_q  <= IDLE;
         pend_q  <= IDLE;
         gap_cnt <= '0;
      end else begin
         st      <= st_nxt;
         mode_q  <= mode_nxt;
         pend_q  <= pend_nxt;
         gap_cnt <= gap_cnt_nxt;
      end
   end

   always_comb begin
      st_nxt      = st;
      mode_nxt    = mode_q;
      pend_nxt    = pend_q;
      gap_cnt_nxt = gap_cnt;
      nm          = IDLE;
      latch       = 1'b0;
      tmr_clr     = 1'b0;
      sync_n      = 1'b0;
      fsync_n     = 1'b0;
      done_n      = 1'b0;

      case (st)
         SEQ_IDLE: begin
            mode_nxt = IDLE;
            if (bus.start && !bus.abort && (bus.mode_mask != 7'd0)) begin
               latch    = 1'b1;
               tmr_clr  = 1'b1;
               mode_nxt = next_mode(bus.mode_mask, IDLE);
               st_nxt   = SEQ_RUN;
               sync_n   = 1'b1;
               fsync_n  = 1'b1;
            end
         end

         SEQ_RUN: begin
            if (mode_end) begin
               nm = next_mode(mask_q, mode_q);
`ifdef PATTERN_SEQ_LOOP_EN
               if (nm == IDLE && loop_q)
                  nm = next_mode(mask_q, IDLE);
`endif
               if (nm == IDLE) begin
                  st_nxt   = SEQ_IDLE;
                  mode_nxt = IDLE;
                  done_n   = 1'b1;
               end else if (gap_q != '0) begin
                  // Mode output keeps the finished mode through the gap.
                  st_nxt      = SEQ_GAP;
                  pend_nxt    = nm;
                  gap_cnt_nxt = '0;
               end else begin
                  mode_nxt = nm;
                  tmr_clr  = 1'b1;
                  sync_n   = 1'b1;
                  fsync_n  = 1'b1;
               end
            end else begin
               sync_n  = line_start;
               fsync_n = frame_start;
            end
         end

         SEQ_GAP: begin
            if (gap_cnt == gap_q - GAP_W'(1)) begin
               st_nxt   = SEQ_RUN;
               mode_nxt = pend_q;
               tmr_clr  = 1'b1;
               sync_n   = 1'b1;
               fsync_n  = 1'b1;
            end else begin
               gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            st_nxt   = SEQ_IDLE;
            mode_nxt = IDLE;
         end
      endcase

      if (bus.abort) begin
         st_nxt   = SEQ_IDLE;
         mode_nxt = IDLE;
         sync_n   = 1'b0;
         fsync_n  = 1'b0;
         done_n   = 1'b0;
         latch    = 1'b0;
      end

      busy_n  = (st_nxt != SEQ_IDLE);
      const_n = (mode_nxt == CONST) ? const_src : 12'd0;
      x_n     = (mode_nxt == RAMP) ? x_src : 2'd0;
      y_n     = (mode_nxt == RAMP) ? y_src : 2'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 1'b0;
         fsync_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         const_out_q <= '0;
         x_out_q     <= '0;
         y_out_q     <= '0;
      end else begin
         sync_q      <= sync_n;
         fsync_q     <= fsync_n;
         done_q      <= done_n;
         busy_q      <= busy_n;
         const_out_q <= const_n;
         x_out_q     <= x_n;
         y_out_q     <= y_n;
      end
   end

   assign bus.f_sync   = fsync_q;
   assign bus.sync     = sync_q;
   assign bus.Mode     = mode_q;
   assign bus.constVal = const_out_q;
   assign bus.X        = x_out_q;
   assign bus.Y        = y_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: expected cycles are queued on start,
// a negedge monitor pops and compares whenever busy or done is presented.
module tb_pattern_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pattern_sequencer_if bus ();

   pattern_sequencer dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

`ifdef PATTERN_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   typedef struct packed {
      logic        f_sync;
      logic        sync;
      logic [2:0]  mode;
      logic [11:0] cval;
      logic [1:0]  x;
      logic [1:0]  y;
      logic        busy;
      logic        done;
   } exp_t;

   typedef struct {
      logic [6:0]  mask;
      int          len;
      int          lines;
      int          frames;
      int          gap;
      logic [11:0] cval;
      logic [1:0]  x;
      logic [1:0]  y;
      logic        loop;
   } cfg_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   exp_t mon_o, mon_e;

   function automatic exp_t observed();
      exp_t o;
      o.f_sync = bus.f_sync;
      o.sync   = bus.sync;
      o.mode   = bus.Mode;
      o.cval   = bus.constVal;
      o.x      = bus.X;
      o.y      = bus.Y;
      o.busy   = bus.busy;
      o.done   = bus.done;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && (bus.busy === 1'b1 || bus.done === 1'b1)) begin
         mon_o = observed();
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", mon_o);
         end else begin
            mon_e = sb.pop_front();
            if (mon_o !== mon_e) begin
               errors++;
               $display("FAIL cycle_output t=%0t actual=%h required=%h", $time, mon_o, mon_e);
            end
         end
      end
   end

   function automatic exp_t entry(input logic fs, input logic s, input int m, input cfg_t c);
      exp_t e;
      e.f_sync = fs;
      e.sync   = s;
      e.mode   = 3'(m);
      e.cval   = (m == 2) ? c.cval : 12'd0;
      e.x      = (m == 7) ? c.x : 2'd0;
      e.y      = (m == 7) ? c.y : 2'd0;
      e.busy   = 1'b1;
      e.done   = 1'b0;
      return e;
   endfunction

   // Reference walk: mode by mode, frame by frame, line by line.
   task automatic gen(input cfg_t c, input int max_n, output int n, output bit completed);
      int len_c, lines_c, frames_c, m, first, nm;
      exp_t d;
      len_c    = (c.len < 2) ? 2 : c.len;
      lines_c  = (c.lines == 0) ? 1 : c.lines;
      frames_c = (c.frames == 0) ? 1 : c.frames;
      first = 0;
      for (int i = 7; i >= 1; i--) if (c.mask[i-1]) first = i;
      m = first;
      n = 0;
      completed = 1'b0;
      while (n < max_n) begin
         for (int f = 0; f < frames_c; f++)
            for (int l = 0; l < lines_c; l++)
               for (int cy = 0; cy < len_c; cy++)
                  if (n < max_n) begin
                     sb.push_back(entry(l == 0 && cy == 0, cy == 0, m, c));
                     n++;
                  end
         if (n >= max_n) break;
         nm = 0;
         for (int i = 7; i > m; i--) if (c.mask[i-1]) nm = i;
         if (nm == 0 && LOOP_EN && c.loop) nm = first;
         if (nm == 0) begin
            d = '0;
            d.done = 1'b1;
            sb.push_back(d);
            n++;
            completed = 1'b1;
            break;
         end
         for (int g = 0; g < c.gap; g++)
            if (n < max_n) begin
               sb.push_back(entry(1'b0, 1'b0, m, c));
               n++;
            end
         m = nm;
      end
   endtask

   task automatic drive_cfg(input cfg_t c);
      bus.mode_mask = c.mask;
      bus.line_len  = 13'(c.len);
      bus.lines     = 8'(c.lines);
      bus.frames    = 4'(c.frames);
      bus.gap_len   = 8'(c.gap);
      bus.const_in  = c.cval;
      bus.x_in      = c.x;
      bus.y_in      = c.y;
      bus.loop      = c.loop;
   endtask

   // Runs one sequence; if it does not complete within max_n cycles it is aborted
   // on the edge that ends cycle max_n.
   task automatic run_case(input string name, input cfg_t c, input int max_n);
      int  n;
      bit  completed;
      cfg_t junk;
      @(posedge clk);
      #1;
      drive_cfg(c);
      bus.start = 1'b1;
      gen(c, max_n, n, completed);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      junk = '{mask: 7'h7f, len: 7, lines: 5, frames: 3, gap: 9, cval: 12'hfff,
               x: 2'd3, y: 2'd1, loop: ~c.loop};
      drive_cfg(junk);
      if (completed) begin
         for (int i = 0; i < 5000; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
         end
         chk({name, "_drain"}, sb.size(), 0);
         sb.delete();
         #1;
         chk({name, "_idle_after"}, {bus.busy, bus.done}, 0);
      end else begin
         repeat (n - 1) @(posedge clk);
         #1;
         bus.abort = 1'b1;
         @(posedge clk);
         #1;
         bus.abort = 1'b0;
         chk({name, "_abort_out"}, 32'(observed()), 0);
         chk({name, "_abort_left"}, sb.size(), 0);
         sb.delete();
         repeat (3) @(posedge clk);
      end
   endtask

   initial begin
      cfg_t c;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      drive_cfg('{mask: 7'd0, len: 0, lines: 0, frames: 0, gap: 0, cval: 12'd0,
                  x: 2'd0, y: 2'd0, loop: 1'b0});
      #1;
      chk("reset_outputs", 32'(observed()), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_release", 32'(observed()), 0);

      c = '{mask: 7'b0000001, len: 10, lines: 3, frames: 1, gap: 0, cval: 12'd0,
            x: 2'd0, y: 2'd0, loop: 1'b0};
      run_case("single_mode", c, 1000);

      c = '{mask: 7'b1000010, len: 4, lines: 2, frames: 2, gap: 0, cval: 12'd12,
            x: 2'd2, y: 2'd2, loop: 1'b0};
      run_case("const_ramp", c, 1000);

      c = '{mask: 7'b0000011, len: 3, lines: 1, frames: 2, gap: 5, cval: 12'd7,
            x: 2'd1, y: 2'd1, loop: 1'b0};
      run_case("gap", c, 1000);

      c = '{mask: 7'b1001100, len: 2, lines: 1, frames: 1, gap: 2, cval: 12'd3,
            x: 2'd1, y: 2'd3, loop: 1'b0};
      run_case("three_modes", c, 1000);

      c = '{mask: 7'b0000110, len: 2, lines: 2, frames: 1, gap: 3, cval: 12'h5a5,
            x: 2'd0, y: 2'd0, loop: 1'b0};
      run_case("const_gap", c, 1000);

      c = '{mask: 7'b0010000, len: 1, lines: 0, frames: 3, gap: 0, cval: 12'd0,
            x: 2'd0, y: 2'd0, loop: 1'b0};
      run_case("degenerate", c, 1000);

      c = '{mask: 7'b0100000, len: 3, lines: 2, frames: 1, gap: 0, cval: 12'd0,
            x: 2'd0, y: 2'd0, loop: 1'b1};
      run_case("loop", c, 13);

      c = '{mask: 7'b0000001, len: 10, lines: 3, frames: 1, gap: 0, cval: 12'd0,
            x: 2'd0, y: 2'd0, loop: 1'b0};
      run_case("abort_mid_line", c, 5);

      // start with an empty mask is ignored
      @(posedge clk);
      #1;
      c.mask = 7'd0;
      drive_cfg(c);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("mask0_busy", bus.busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("mask0_outputs", 32'(observed()), 0);

      // abort beats start in IDLE
      c.mask = 7'b0000001;
      drive_cfg(c);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("abort_start_idle", 32'(observed()), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_start_still_idle", bus.busy, 0);

      // asynchronous reset in the middle of a line
      c = '{mask: 7'b0000010, len: 10, lines: 3, frames: 1, gap: 0, cval: 12'd9,
            x: 2'd0, y: 2'd0, loop: 1'b0};
      @(posedge clk);
      #1;
      drive_cfg(c);
      bus.start = 1'b1;
      begin
         int  n;
         bit  completed;
         gen(c, 4, n, completed);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_out", 32'(observed()), 0);
      chk("async_reset_left", sb.size(), 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_idle", bus.busy, 0);

      // restart after reset still works
      c = '{mask: 7'b1000000, len: 2, lines: 1, frames: 2, gap: 0, cval: 12'd0,
            x: 2'd3, y: 2'd2, loop: 1'b0};
      run_case("restart", c, 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Controller that drives the pattern generator's `f_sync`, `sync`, `Mode`, `constVal`, `X` and `Y` inputs. It steps through a programmed set of pattern modes and emits a fixed number of lines and frames per mode, so a full pattern test runs without per-line software control. The sequencer sits between the register/host interface and the pattern generator. All its outputs are registered.

## Interface
- `LINE_W`, 13, width of the line-length field (cycles per line)
- `LINES_W`, 8, width of the lines-per-frame field
- `FRAMES_W`, 4, width of the frames-per-mode field
- `GAP_W`, 8, width of the inter-mode gap field
- `clk` in 1: master clock
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: begin sequence; sampled in IDLE only
- `abort` in 1: synchronous stop; returns to IDLE
- `mode_mask` in 7: bit i enables mode i+1
- `line_len` in LINE_W: cycles per line; values below 2 are treated as 2
- `lines` in LINES_W: lines per frame; 0 is treated as 1
- `frames` in FRAMES_W: frames per mode; 0 is treated as 1
- `gap_len` in GAP_W: idle cycles between modes; 0 means no gap
- `const_in` in 12: constant value for mode 2
- `x_in`, `y_in` in 2 each: ramp deltas for mode 7
- `loop` in 1: wrap to the first enabled mode after the last one
- `f_sync` out 1, `sync` out 1, `Mode` out 3, `constVal` out 12, `X` out 2, `Y` out 2: generator controls
- `busy` out 1: sequence active
- `done` out 1: one-cycle pulse on normal completion

## Operation
- States: IDLE, RUN, GAP.
- **Starting a sequence.** In IDLE, `start`=1 with a non-zero `mode_mask` does two things:
  - Latches all config inputs.
  - Selects the lowest enabled mode and enters RUN.
- **Ignored start.** `start` is ignored when `mode_mask`==0, and ignored while `busy`.
- **RUN.**
  - `sync`=1 on the first cycle of every line.
  - `f_sync`=1 on the first cycle of the first line of each frame.
  - A line lasts `line_len` cycles. A mode lasts `lines`×`frames` lines.
- **End of last line of a mode.**
  - Next mode = lowest enabled mode above the current one.
  - If none remains and `loop`=1, next mode = lowest enabled mode.
  - If none remains and `loop`=0, the sequence completes: `done` pulses and the block returns to IDLE.
  - Otherwise, with `gap_len`>0, enter GAP for `gap_len` cycles (`sync`=`f_sync`=0, `Mode` holds the old value), then RUN with the new mode.
  - With `gap_len`==0, the new mode's first line starts in the very next cycle.
- **Output values by mode.**
  - `constVal` = latched `const_in` in mode 2, else 0.
  - `X`/`Y` = latched `x_in`/`y_in` in mode 7, else 0.
- **IDLE outputs.** `Mode`=0 and all other outputs are 0.
- **Abort.** `abort` in any state → IDLE at the next edge. All outputs are 0, no `done` pulse.
  - If `abort` and `start` are both high in IDLE, `abort` wins.
- **Counter wrap.** Counters are sized to their fields, and the terminal comparison uses the clamped values. No counter wraps inside a line, frame or mode.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-sequence aborts immediately and asynchronously.
- `start` sampled at edge E0 → `busy`, `Mode`, `sync` and `f_sync` are high in the cycle after E0. Latency is 1 cycle.
- Line k of a mode starts `k`×`line_len` cycles after the mode's first cycle.
- `done` and the fall of `busy` occur in the cycle immediately after the last cycle of the last line.
- A mode change, or a GAP exit, updates `Mode` in the same cycle as the new mode's first `sync`/`f_sync`.
- Config inputs changing during `busy` have no effect.

## Configuration
- Macro `PATTERN_SEQ_LOOP_EN`.
- Defined: the `loop` input is honoured.
- Undefined: the `loop` port remains but is ignored (treated as 0), and the wrap logic is not compiled.

## Structure
- Shared package `pattern_pkg` holds:
  - `mode_t` enum: IDLE=0, REGULAR=1, CONST=2, WHITE1=3, BLACK1=4, WHITE2=5, BLACK2=6, RAMP=7.
  - `seq_state_t` enum: IDLE, RUN, GAP.
  - A `MODE_W`=3 constant.
- Sub-module `pattern_line_timer`: holds the cycle, line and frame counters. It produces `line_start`, `frame_start` and `mode_end` strobes for the top-level FSM.

## Test plan
- **Single mode.** `mode_mask`=7'b0000001, `line_len`=10, `lines`=3, `frames`=1, `start` at E0 → `Mode`=1 and `sync` high in cycles 1, 11, 21; `f_sync` only in cycle 1; `done` in cycle 31; `busy` low from cycle 31.
- **Const and ramp.** `mode_mask`=7'b1000010, `const_in`=12, `x_in`=`y_in`=2, `line_len`=4, `lines`=2, `frames`=2, `gap_len`=0 → mode 2 for 16 cycles with `constVal`=12, then mode 7 for 16 cycles with `X`=`Y`=2 and `constVal`=0; `f_sync` every 8 cycles.
- **Gap between modes.** `gap_len`=5, `mode_mask`=7'b0000011 → 5 cycles with `sync`=0 and `Mode`=1 between the modes, then `Mode`=2 with `sync`=`f_sync`=1.
- **Loop.** With `PATTERN_SEQ_LOOP_EN`, `loop`=1, `mode_mask`=7'b0100000 → mode 6 repeats indefinitely with no `done`. Without the macro → `done` after one pass.
- **Abort.** `abort` mid-line → all outputs 0 next cycle, no `done`. A `start` on the same cycle in IDLE → stays IDLE.
- **Degenerate config.** `mode_mask`=0 with `start` → `busy` stays 0. `line_len`=1, `lines`=0 → `sync` every 2 cycles, 1 line per frame.
